// File: rtl/matrix_multiply_engine.sv
// Matrix multiply engine: Z = X*Y (or Z += X*Y) over three internal RAMs with host access.
// Optional macro MATMUL_SATURATE_EN clamps written elements instead of wrapping.
//
// state   | meaning
// IDLE    | host owns the RAMs, waiting for start
// CHECK   | validate latched dimensions
// MAC     | one X/Y read per cycle for the current element
// DRAIN   | absorb last product (and old Z when accumulating)
// WRITE   | store element to Z, advance to next element
// FINISH  | done pulse, return to IDLE
module matrix_multiply_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dim_m,
  input  logic [ADDR_WIDTH-1:0] dim_k,
  input  logic [ADDR_WIDTH-1:0] dim_n,
  input  logic                  signed_mode,
  input  logic                  acc_mode,
  input  logic [1:0]            ram_sel,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int ACC_W  = 2*DATA_WIDTH + ADDR_WIDTH;
  localparam logic [2*ADDR_WIDTH-1:0] DIM_LIMIT = (2*ADDR_WIDTH)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]   ONE_A     = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MAC, S_DRAIN, S_WRITE, S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic                  sgn_q, sgn_d, accm_q, accm_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] k_cnt_q, k_cnt_d, r_q, r_d, c_q, c_d;
  logic [ADDR_WIDTH-1:0] x_row_q, x_row_d, x_addr_q, x_addr_d;
  logic [ADDR_WIDTH-1:0] y_addr_q, y_addr_d, z_addr_q, z_addr_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  mac_vld_q, mac_vld_d;
  logic [DATA_WIDTH-1:0] ram_data_out_q, ram_data_out_d;

  logic [DATA_WIDTH-1:0] x_mem [DEPTH];
  logic [DATA_WIDTH-1:0] y_mem [DEPTH];
  logic [DATA_WIDTH-1:0] z_mem [DEPTH];
  logic [DATA_WIDTH-1:0] x_rd_q, y_rd_q, z_rd_q;

  logic [2*ADDR_WIDTH-1:0] mk, kn, mn;
  logic                    dim_err, last_elem;
  logic [PROD_W-1:0]       x_ext, y_ext, prod;
  logic [ACC_W-1:0]        prod_ext, z_ext;
  logic [DATA_WIDTH-1:0]   z_wdata;

  // dimension validation and element sequencing
  always_comb begin
    mk = {{ADDR_WIDTH{1'b0}}, dim_m_q} * {{ADDR_WIDTH{1'b0}}, dim_k_q};
    kn = {{ADDR_WIDTH{1'b0}}, dim_k_q} * {{ADDR_WIDTH{1'b0}}, dim_n_q};
    mn = {{ADDR_WIDTH{1'b0}}, dim_m_q} * {{ADDR_WIDTH{1'b0}}, dim_n_q};
    dim_err = (dim_m_q == '0) || (dim_k_q == '0) || (dim_n_q == '0) ||
              (mk > DIM_LIMIT) || (kn > DIM_LIMIT) || (mn > DIM_LIMIT);
    last_elem = (r_q == dim_m_q - ONE_A) && (c_q == dim_n_q - ONE_A);
  end

  // operands are extended to full product width so one multiplier serves both modes
  always_comb begin
    x_ext    = sgn_q ? {{DATA_WIDTH{x_rd_q[DATA_WIDTH-1]}}, x_rd_q}
                     : {{DATA_WIDTH{1'b0}}, x_rd_q};
    y_ext    = sgn_q ? {{DATA_WIDTH{y_rd_q[DATA_WIDTH-1]}}, y_rd_q}
                     : {{DATA_WIDTH{1'b0}}, y_rd_q};
    prod     = x_ext * y_ext;
    prod_ext = {{ADDR_WIDTH{sgn_q & prod[PROD_W-1]}}, prod};
    z_ext    = {{(DATA_WIDTH+ADDR_WIDTH){sgn_q & z_rd_q[DATA_WIDTH-1]}}, z_rd_q};
  end

`ifdef MATMUL_SATURATE_EN
  always_comb begin
    z_wdata = acc_q[DATA_WIDTH-1:0];
    if (sgn_q) begin
      if (acc_q[ACC_W-1] && !(&acc_q[ACC_W-1:DATA_WIDTH-1]))
        z_wdata = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else if (!acc_q[ACC_W-1] && (|acc_q[ACC_W-1:DATA_WIDTH-1]))
        z_wdata = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (|acc_q[ACC_W-1:DATA_WIDTH]) begin
      z_wdata = {DATA_WIDTH{1'b1}};
    end
  end
`else
  always_comb z_wdata = acc_q[DATA_WIDTH-1:0];
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = dim_err ? S_FINISH : S_MAC;
      S_MAC:    if (k_cnt_q == '0) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_WRITE;
      S_WRITE:  state_d = last_elem ? S_FINISH : S_MAC;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FINISH);
    err          = err_q;
    ram_data_out = ram_data_out_q;
  end

  // datapath next values
  always_comb begin
    dim_m_d   = dim_m_q;
    dim_k_d   = dim_k_q;
    dim_n_d   = dim_n_q;
    sgn_d     = sgn_q;
    accm_d    = accm_q;
    err_d     = err_q;
    k_cnt_d   = k_cnt_q;
    r_d       = r_q;
    c_d       = c_q;
    x_row_d   = x_row_q;
    x_addr_d  = x_addr_q;
    y_addr_d  = y_addr_q;
    z_addr_d  = z_addr_q;
    mac_vld_d = (state_q == S_MAC);
    // each product lands one cycle after its read; old Z joins in DRAIN
    acc_d     = acc_q + (mac_vld_q ? prod_ext : '0)
                      + ((state_q == S_DRAIN && accm_q) ? z_ext : '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dim_m_d = dim_m;
          dim_k_d = dim_k;
          dim_n_d = dim_n;
          sgn_d   = signed_mode;
          accm_d  = acc_mode;
          err_d   = 1'b0;
        end
      end
      S_CHECK: begin
        err_d    = dim_err;
        k_cnt_d  = dim_k_q - ONE_A;
        r_d      = '0;
        c_d      = '0;
        x_row_d  = '0;
        x_addr_d = '0;
        y_addr_d = '0;
        z_addr_d = '0;
        acc_d    = '0;
      end
      S_MAC: begin
        x_addr_d = x_addr_q + ONE_A;
        y_addr_d = y_addr_q + dim_n_q;
        if (k_cnt_q != '0) k_cnt_d = k_cnt_q - ONE_A;
      end
      S_WRITE: begin
        acc_d    = '0;
        k_cnt_d  = dim_k_q - ONE_A;
        z_addr_d = z_addr_q + ONE_A;
        if (c_q == dim_n_q - ONE_A) begin
          c_d      = '0;
          r_d      = r_q + ONE_A;
          x_row_d  = x_row_q + dim_k_q;
          x_addr_d = x_row_q + dim_k_q;
          y_addr_d = '0;
        end else begin
          c_d      = c_q + ONE_A;
          x_addr_d = x_row_q;
          y_addr_d = c_q + ONE_A;
        end
      end
      default: ;
    endcase
  end

  // host read port is blanked whenever the engine owns the RAMs
  always_comb begin
    ram_data_out_d = '0;
    if (state_d == S_IDLE) begin
      case (ram_sel)
        2'b00:   ram_data_out_d = x_mem[ram_addr];
        2'b01:   ram_data_out_d = y_mem[ram_addr];
        2'b10:   ram_data_out_d = z_mem[ram_addr];
        default: ram_data_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dim_m_q        <= '0;
      dim_k_q        <= '0;
      dim_n_q        <= '0;
      sgn_q          <= 1'b0;
      accm_q         <= 1'b0;
      err_q          <= 1'b0;
      k_cnt_q        <= '0;
      r_q            <= '0;
      c_q            <= '0;
      x_row_q        <= '0;
      x_addr_q       <= '0;
      y_addr_q       <= '0;
      z_addr_q       <= '0;
      acc_q          <= '0;
      mac_vld_q      <= 1'b0;
      ram_data_out_q <= '0;
    end else begin
      dim_m_q        <= dim_m_d;
      dim_k_q        <= dim_k_d;
      dim_n_q        <= dim_n_d;
      sgn_q          <= sgn_d;
      accm_q         <= accm_d;
      err_q          <= err_d;
      k_cnt_q        <= k_cnt_d;
      r_q            <= r_d;
      c_q            <= c_d;
      x_row_q        <= x_row_d;
      x_addr_q       <= x_addr_d;
      y_addr_q       <= y_addr_d;
      z_addr_q       <= z_addr_d;
      acc_q          <= acc_d;
      mac_vld_q      <= mac_vld_d;
      ram_data_out_q <= ram_data_out_d;
    end
  end

  // RAM arrays keep their contents through reset
  always_ff @(posedge clk) begin
    x_rd_q <= x_mem[x_addr_q];
    y_rd_q <= y_mem[y_addr_q];
    z_rd_q <= z_mem[z_addr_q];
    if (rst) begin
      if (state_q == S_WRITE) begin
        z_mem[z_addr_q] <= z_wdata;
      end else if (state_q == S_IDLE && ram_wen) begin
        case (ram_sel)
          2'b00:   x_mem[ram_addr] <= ram_data_in;
          2'b01:   y_mem[ram_addr] <= ram_data_in;
          2'b10:   z_mem[ram_addr] <= ram_data_in;
          default: ;
        endcase
      end
    end
  end

endmodule
